// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared types and constants for the paddle driver.
package pong_pkg;

    localparam int PADDLE_ROWS = 16;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        REPEAT
    } drv_state_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN
    } dir_t;

endpackage

// File: rtl/paddle_driver_if.sv
// rtl/paddle_driver_if.sv - board-side pins and paddle step outputs of one paddle driver.
interface paddle_driver_if;
    import pong_pkg::*;

    logic                   btn_up;
    logic                   btn_down;
    logic                   frame_tick;
    logic [PADDLE_ROWS-1:0] paddle;
    logic [3:0]             ball_row;
    logic                   ai_mode;
    logic                   step_up;
    logic                   step_down;
    logic                   moving;

    modport master (
        output btn_up, btn_down, frame_tick, paddle, ball_row, ai_mode,
        input  step_up, step_down, moving
    );

    modport slave (
        input  btn_up, btn_down, frame_tick, paddle, ball_row, ai_mode,
        output step_up, step_down, moving
    );
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchroniser plus stability counter for one raw button.
module btn_debounce #(
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level
);
    logic                     sync1;
    logic                     sync2;
    logic [DEBOUNCE_BITS-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (&cnt) begin
                // Wrap: input has disagreed for 2**DEBOUNCE_BITS consecutive cycles.
                cnt   <= '0;
                level <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/paddle_driver.sv
// rtl/paddle_driver.sv - debounced hold-to-repeat paddle stepper; AI_PADDLE_EN adds a ball-tracking mode.
module paddle_driver
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_BITS = 16,
    parameter int FIRST_DELAY   = 8,
`ifdef AI_PADDLE_EN
    parameter int AI_PERIOD     = 3,
`endif
    parameter int REPEAT_PERIOD = 2
) (
    input logic             clk,
    input logic             reset,
    paddle_driver_if.slave  bus
);
    logic       up_db;
    logic       down_db;
    dir_t       dir;
    drv_state_t state, state_n;
    logic [7:0] cnt, cnt_n;
    dir_t       dir_q, dir_n;
    dir_t       fire_dir;
    logic       fire_up;
    logic       fire_down;
    logic       step_up_q;
    logic       step_down_q;

    btn_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_db_up (
        .clk   (clk),
        .reset (reset),
        .btn   (bus.btn_up),
        .level (up_db)
    );

    btn_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_db_down (
        .clk   (clk),
        .reset (reset),
        .btn   (bus.btn_down),
        .level (down_db)
    );

    always_comb begin
        dir = DIR_NONE;
        if (up_db && !down_db)      dir = DIR_UP;
        else if (down_db && !up_db) dir = DIR_DOWN;
    end

`ifdef AI_PADDLE_EN
    logic       ai_q;
    logic [3:0] top_row;
    logic [3:0] bot_row;
    logic [4:0] row_sum;
    logic [3:0] ctr_row;
    dir_t       ai_dir;

    always_comb begin
        top_row = 4'd0;
        bot_row = 4'd0;
        for (int i = PADDLE_ROWS - 1; i >= 0; i--) begin
            if (bus.paddle[i]) top_row = 4'(i);
        end
        for (int i = 0; i < PADDLE_ROWS; i++) begin
            if (bus.paddle[i]) bot_row = 4'(i);
        end
        row_sum = {1'b0, top_row} + {1'b0, bot_row};
        ctr_row = row_sum[4:1];
        ai_dir  = DIR_NONE;
        if (|bus.paddle) begin
            if (bus.ball_row < ctr_row)      ai_dir = DIR_UP;
            else if (bus.ball_row > ctr_row) ai_dir = DIR_DOWN;
        end
    end
`endif

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        dir_n    = dir_q;
        fire_dir = DIR_NONE;
`ifdef AI_PADDLE_EN
        if (bus.ai_mode != ai_q) begin
            state_n = IDLE;
        end else if (bus.ai_mode) begin
            state_n = REPEAT;
            if (state == IDLE) begin
                cnt_n = 8'(AI_PERIOD);
            end else if (bus.frame_tick) begin
                if (cnt <= 8'd1) begin
                    fire_dir = ai_dir;
                    cnt_n    = 8'(AI_PERIOD);
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
        end else
`endif
        begin
            case (state)
                IDLE: begin
                    if (dir != DIR_NONE) begin
                        fire_dir = dir;
                        dir_n    = dir;
                        cnt_n    = 8'(FIRST_DELAY);
                        state_n  = FIRST;
                    end
                end
                default: begin
                    // A changed direction drops to IDLE so the new one restarts with an immediate step.
                    if (dir != dir_q) begin
                        state_n = IDLE;
                    end else if (bus.frame_tick) begin
                        if (cnt <= 8'd1) begin
                            fire_dir = dir_q;
                            cnt_n    = 8'(REPEAT_PERIOD);
                            state_n  = REPEAT;
                        end else begin
                            cnt_n = cnt - 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    // Wall limits mask the pulse only; the sequencer keeps running. A pulse never follows a pulse directly.
    assign fire_up   = (fire_dir == DIR_UP) && !bus.paddle[0] && !step_up_q && !step_down_q;
    assign fire_down = (fire_dir == DIR_DOWN) && !bus.paddle[PADDLE_ROWS-1] && !step_up_q && !step_down_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            dir_q       <= DIR_NONE;
            step_up_q   <= 1'b0;
            step_down_q <= 1'b0;
`ifdef AI_PADDLE_EN
            ai_q        <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            dir_q       <= dir_n;
            step_up_q   <= fire_up;
            step_down_q <= fire_down;
`ifdef AI_PADDLE_EN
            ai_q        <= bus.ai_mode;
`endif
        end
    end

    assign bus.step_up   = step_up_q;
    assign bus.step_down = step_down_q;
    assign bus.moving    = (state != IDLE);
endmodule

// File: tb/tb_paddle_driver.sv
// tb/tb_paddle_driver.sv - directed self-checking bench for paddle_driver (AI_PADDLE_EN steps are conditional).
module tb_paddle_driver;
    logic clk = 1'b0;
    logic reset;
    paddle_driver_if bus();

    paddle_driver #(.DEBOUNCE_BITS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int up_cnt = 0;
    int down_cnt = 0;
    int ticks = 0;
    int shape_err = 0;
    int up_t[64];
    int down_t[64];
    logic prev_up = 1'b0;
    logic prev_down = 1'b0;

    // Pulse monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.frame_tick) ticks++;
        if (bus.step_up && bus.step_down) shape_err++;
        if ((bus.step_up && prev_up) || (bus.step_down && prev_down)) shape_err++;
        if (bus.step_up) begin
            if (up_cnt < 64) up_t[up_cnt] = ticks;
            up_cnt++;
        end
        if (bus.step_down) begin
            if (down_cnt < 64) down_t[down_cnt] = ticks;
            down_cnt++;
        end
        prev_up   = bus.step_up;
        prev_down = bus.step_down;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame();
        bus.frame_tick = 1'b1;
        cyc(1);
        bus.frame_tick = 1'b0;
        cyc(3);
    endtask

    int u0, d0, t0, lat;
    int exp3[4] = '{0, 8, 10, 12};

    initial begin
        reset          = 1'b1;
        bus.btn_up     = 1'b0;
        bus.btn_down   = 1'b0;
        bus.frame_tick = 1'b0;
        bus.paddle     = 16'h00F0;
        bus.ball_row   = 4'd0;
        bus.ai_mode    = 1'b0;
        cyc(2);

        // 1: reset with up held
        bus.btn_up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("rst_step_up", bus.step_up, 0);
            check("rst_step_down", bus.step_down, 0);
            check("rst_moving", bus.moving, 0);
        end
        reset = 1'b0;
        cyc(1);
        check("post_rst_step_up", bus.step_up, 0);
        check("post_rst_step_down", bus.step_down, 0);
        check("post_rst_moving", bus.moving, 0);
        bus.btn_up = 1'b0;
        cyc(12);

        // 2: bounce then settle
        u0 = up_cnt;
        for (int i = 0; i < 10; i++) begin
            bus.btn_up = (i % 2 == 0);
            cyc(2);
        end
        check("bounce_no_pulse", up_cnt - u0, 0);
        bus.btn_up = 1'b1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (bus.step_up && lat < 0) lat = i;
        end
        check("bounce_latency", lat, 7);
        bus.btn_up = 1'b0;
        cyc(12);
        check("bounce_one_pulse", up_cnt - u0, 1);
        check("bounce_idle", bus.moving, 0);

        // 3: repeat timing on down
        d0 = down_cnt;
        t0 = ticks;
        bus.btn_down = 1'b1;
        for (int i = 0; i < 30 && down_cnt == d0; i++) cyc(1);
        check("rep_first_seen", down_cnt - d0, 1);
        for (int i = 0; i < 12; i++) frame();
        check("rep_count", down_cnt - d0, 4);
        for (int k = 0; k < 4; k++) check($sformatf("rep_tick%0d", k), down_t[d0 + k] - t0, exp3[k]);
        check("rep_moving", bus.moving, 1);
        bus.btn_down = 1'b0;
        cyc(12);
        check("rep_release_idle", bus.moving, 0);

        // 4: both held
        u0 = up_cnt;
        d0 = down_cnt;
        bus.btn_up = 1'b1;
        cyc(15);
        bus.btn_down = 1'b1;
        cyc(15);
        for (int i = 0; i < 10; i++) frame();
        check("both_up_pulses", up_cnt - u0, 1);
        check("both_down_pulses", down_cnt - d0, 0);
        check("both_idle", bus.moving, 0);
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        cyc(15);
        check("both_release_pulses", up_cnt + down_cnt - u0 - d0, 1);

        // 5: top wall
        u0 = up_cnt;
        bus.paddle = 16'h000F;
        bus.btn_up = 1'b1;
        cyc(15);
        for (int i = 0; i < 20; i++) frame();
        check("wall_no_pulse", up_cnt - u0, 0);
        check("wall_moving", bus.moving, 1);
        bus.btn_up = 1'b0;
        cyc(12);
        check("wall_release_idle", bus.moving, 0);

`ifdef AI_PADDLE_EN
        // 6: AI tracking
        u0 = up_cnt;
        d0 = down_cnt;
        bus.paddle   = 16'h0F00;
        bus.ball_row = 4'd3;
        bus.ai_mode  = 1'b1;
        cyc(3);
        t0 = ticks;
        for (int i = 0; i < 9; i++) frame();
        check("ai_up_count", up_cnt - u0, 3);
        for (int k = 0; k < 3; k++) check($sformatf("ai_tick%0d", k), up_t[u0 + k] - t0, 3 * (k + 1));
        check("ai_moving", bus.moving, 1);
        bus.ball_row = 4'd9;
        for (int i = 0; i < 6; i++) frame();
        check("ai_centered_up", up_cnt - u0, 3);
        check("ai_centered_down", down_cnt - d0, 0);
        bus.ai_mode = 1'b0;
        cyc(3);
        check("ai_off_idle", bus.moving, 0);
`endif

        check("pulse_shape", shape_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
